id_ex_stage: RTL and testbench

- Pipeline stage register between decode (ID) and the 32-bit execute ALU.
- Captures decoded operands and control, and drives the ALU inputs (in1, in2, ALUControl, shamt) with EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts one bubble per hazard.
- Supports hold (downstream busy) and flush (branch redirect).

---
 rtl/id_ex_stage.sv | 172 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for a 32-bit ALU. It captures the decoded operands and control,
// forwards from EX/MEM and MEM/WB, and inserts one bubble per load-use hazard.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hold,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_use_imm,
  input  logic [3:0]    id_alu_ctrl,
  input  logic [4:0]    id_shamt,
  input  logic [RW-1:0] id_dest,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_dest,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_dest,
  input  logic [DW-1:0] memwb_result,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_in1,
  output logic [DW-1:0] ex_in2,
  output logic [DW-1:0] ex_store_data,
  output logic [3:0]    ex_alu_ctrl,
  output logic [4:0]    ex_shamt,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  logic          r_valid, r_use_imm, r_reg_write, r_mem_read, r_mem_write;
  logic [RW-1:0] r_rs, r_rt, r_dest;
  logic [DW-1:0] r_rs_data, r_rt_data, r_imm;
  logic [3:0]    r_alu_ctrl;
  logic [4:0]    r_shamt;

  logic          w_haz, w_bubble;
  logic          w_nxt_valid, w_nxt_use_imm, w_nxt_reg_write, w_nxt_mem_read, w_nxt_mem_write;
  logic [RW-1:0] w_nxt_rs, w_nxt_rt, w_nxt_dest;
  logic [DW-1:0] w_nxt_rs_data, w_nxt_rt_data, w_nxt_imm;
  logic [3:0]    w_nxt_alu_ctrl;
  logic [4:0]    w_nxt_shamt;
  logic [DW-1:0] w_fwd_rs, w_fwd_rt;

  // A write port hits a source only when it writes that register; r0 never matches.
  function automatic logic src_hit(input logic we, input logic [RW-1:0] dst,
                                   input logic [RW-1:0] src);
    return we && (dst == src) && (src != {RW{1'b0}});
  endfunction

  function automatic logic [DW-1:0] fwd(input logic [RW-1:0] src, input logic [DW-1:0] cap,
                                        input logic xw, input logic [RW-1:0] xd,
                                        input logic [DW-1:0] xr, input logic mw,
                                        input logic [RW-1:0] md, input logic [DW-1:0] mr);
    logic [DW-1:0] v;
    if (src_hit(xw, xd, src)) begin
      v = xr;
    end else if (src_hit(mw, md, src)) begin
      v = mr;
    end else begin
      v = cap;
    end
    return v;
  endfunction

  // Load-use hazard against the load in EX, and the stall request it raises.
  always_comb begin
    w_haz = r_valid && r_mem_read && (r_dest != {RW{1'b0}}) && id_valid &&
            ((id_rs == r_dest) ||
             ((id_rt == r_dest) && (!id_use_imm || id_mem_write)));
    stall = w_haz && !flush && !hold;
  end

  // Next EX contents: a bubble on flush or hazard, otherwise the ID fields with WB bypass.
  always_comb begin
    w_bubble = flush || w_haz;
    if (w_bubble) begin
      w_nxt_valid     = 1'b0;
      w_nxt_rs        = {RW{1'b0}};
      w_nxt_rt        = {RW{1'b0}};
      w_nxt_rs_data   = {DW{1'b0}};
      w_nxt_rt_data   = {DW{1'b0}};
      w_nxt_imm       = {DW{1'b0}};
      w_nxt_use_imm   = 1'b0;
      w_nxt_alu_ctrl  = 4'b0000;
      w_nxt_shamt     = 5'd0;
      w_nxt_dest      = {RW{1'b0}};
      w_nxt_reg_write = 1'b0;
      w_nxt_mem_read  = 1'b0;
      w_nxt_mem_write = 1'b0;
    end else begin
      w_nxt_valid     = id_valid;
      w_nxt_rs        = id_rs;
      w_nxt_rt        = id_rt;
      w_nxt_rs_data   = src_hit(memwb_reg_write, memwb_dest, id_rs) ? memwb_result : id_rs_data;
      w_nxt_rt_data   = src_hit(memwb_reg_write, memwb_dest, id_rt) ? memwb_result : id_rt_data;
      w_nxt_imm       = id_imm;
      w_nxt_use_imm   = id_use_imm;
      w_nxt_alu_ctrl  = id_alu_ctrl;
      w_nxt_shamt     = id_shamt;
      w_nxt_dest      = id_dest;
      w_nxt_reg_write = id_reg_write;
      w_nxt_mem_read  = id_mem_read;
      w_nxt_mem_write = id_mem_write;
    end
  end

  // EX register bank; hold freezes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid     <= 1'b0;
      r_rs        <= {RW{1'b0}};
      r_rt        <= {RW{1'b0}};
      r_rs_data   <= {DW{1'b0}};
      r_rt_data   <= {DW{1'b0}};
      r_imm       <= {DW{1'b0}};
      r_use_imm   <= 1'b0;
      r_alu_ctrl  <= 4'b0000;
      r_shamt     <= 5'd0;
      r_dest      <= {RW{1'b0}};
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (!hold) begin
      r_valid     <= w_nxt_valid;
      r_rs        <= w_nxt_rs;
      r_rt        <= w_nxt_rt;
      r_rs_data   <= w_nxt_rs_data;
      r_rt_data   <= w_nxt_rt_data;
      r_imm       <= w_nxt_imm;
      r_use_imm   <= w_nxt_use_imm;
      r_alu_ctrl  <= w_nxt_alu_ctrl;
      r_shamt     <= w_nxt_shamt;
      r_dest      <= w_nxt_dest;
      r_reg_write <= w_nxt_reg_write;
      r_mem_read  <= w_nxt_mem_read;
      r_mem_write <= w_nxt_mem_write;
    end
  end

  // Operand forwarding keeps tracking later stages even while the register is held.
  always_comb begin
    w_fwd_rs = fwd(r_rs, r_rs_data, exmem_reg_write, exmem_dest, exmem_result,
                   memwb_reg_write, memwb_dest, memwb_result);
    w_fwd_rt = fwd(r_rt, r_rt_data, exmem_reg_write, exmem_dest, exmem_result,
                   memwb_reg_write, memwb_dest, memwb_result);
    ex_in1        = w_fwd_rs;
    ex_in2        = r_use_imm ? r_imm : w_fwd_rt;
    ex_store_data = w_fwd_rt;
  end

  assign ex_valid     = r_valid;
  assign ex_alu_ctrl  = r_alu_ctrl;
  assign ex_shamt     = r_shamt;
  assign ex_dest      = r_dest;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for capture and forwarding, plus
// hand-written sequences for load-use, store hazard, flush, hold and async reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, hold, flush, id_valid, id_use_imm;
  logic [4:0]  id_rs, id_rt, id_dest, id_shamt, exmem_dest, memwb_dest, ex_shamt, ex_dest;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic [3:0]  id_alu_ctrl, ex_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, exmem_reg_write, memwb_reg_write;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [31:0] ex_in1, ex_in2, ex_store_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_ctrl(id_alu_ctrl),
    .id_shamt(id_shamt), .id_dest(id_dest), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_dest(exmem_dest), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_dest(memwb_dest), .memwb_result(memwb_result),
    .stall(stall), .ex_valid(ex_valid), .ex_in1(ex_in1), .ex_in2(ex_in2),
    .ex_store_data(ex_store_data), .ex_alu_ctrl(ex_alu_ctrl), .ex_shamt(ex_shamt),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  typedef struct {
    logic [4:0]  rs, rt;
    logic [31:0] rs_d, rt_d, imm;
    logic        use_imm;
    logic [3:0]  ctrl;
    logic        valid;
    logic        xw;
    logic [4:0]  xd;
    logic [31:0] xr;
    logic        mw;
    logic [4:0]  md;
    logic [31:0] mr;
    logic [31:0] e_in1, e_in2, e_st;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_fwd();
    exmem_reg_write = 1'b0; exmem_dest = 5'd0; exmem_result = 32'd0;
    memwb_reg_write = 1'b0; memwb_dest = 5'd0; memwb_result = 32'd0;
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] rsd,
                        input logic [31:0] rtd, input logic [31:0] imm, input logic ui,
                        input logic [3:0] ctrl, input logic [4:0] dest, input logic rw,
                        input logic mr, input logic mw, input logic v);
    id_rs = rs; id_rt = rt; id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_use_imm = ui; id_alu_ctrl = ctrl; id_shamt = 5'd0; id_dest = dest;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_valid = v;
  endtask

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                              input logic [31:0] rsd, input logic [31:0] rtd,
                              input logic [31:0] imm, input logic ui, input logic [3:0] ctrl,
                              input logic v, input logic xw, input logic [4:0] xd,
                              input logic [31:0] xr, input logic mw, input logic [4:0] md,
                              input logic [31:0] mr, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] es);
    vec_t t;
    t.rs = rs; t.rt = rt; t.rs_d = rsd; t.rt_d = rtd; t.imm = imm; t.use_imm = ui;
    t.ctrl = ctrl; t.valid = v; t.xw = xw; t.xd = xd; t.xr = xr; t.mw = mw; t.md = md;
    t.mr = mr; t.e_in1 = e1; t.e_in2 = e2; t.e_st = es;
    return t;
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = mk(5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, 4'b0001, 1'b1,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd5, 32'd7, 32'd7);
    vt[1] = mk(5'd3, 5'd4, 32'd10, 32'd9, 32'hFFFF_FFF0, 1'b1, 4'b0011, 1'b1,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd10, 32'hFFFF_FFF0, 32'd9);
    vt[2] = mk(5'd5, 5'd6, 32'd1, 32'd3, 32'd0, 1'b0, 4'b0010, 1'b1,
               1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'd0, 32'hAA, 32'd3, 32'd3);
    vt[3] = mk(5'd0, 5'd7, 32'h11, 32'h22, 32'd0, 1'b0, 4'b0001, 1'b1,
               1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 32'h11, 32'h22, 32'h22);
    vt[4] = mk(5'd9, 5'd8, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0001, 1'b1,
               1'b1, 5'd8, 32'hA1, 1'b1, 5'd8, 32'hB2, 32'd1, 32'hA1, 32'hA1);
    vt[5] = mk(5'd10, 5'd11, 32'h40, 32'h50, 32'h8, 1'b1, 4'b0001, 1'b1,
               1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h77, 32'h77, 32'h8, 32'h50);
    vt[6] = mk(5'd12, 5'd13, 32'd3, 32'd4, 32'd0, 1'b0, 4'b1101, 1'b0,
               1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd3, 32'd4, 32'd4);

    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    clr_fwd();
    set_id(5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_in1", ex_in1, 32'd0);
    chk("reset_dest", {27'd0, ex_dest}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      set_id(vt[i].rs, vt[i].rt, vt[i].rs_d, vt[i].rt_d, vt[i].imm, vt[i].use_imm,
             vt[i].ctrl, 5'd20, 1'b1, 1'b0, 1'b0, vt[i].valid);
      exmem_reg_write = vt[i].xw; exmem_dest = vt[i].xd; exmem_result = vt[i].xr;
      memwb_reg_write = vt[i].mw; memwb_dest = vt[i].md; memwb_result = vt[i].mr;
      tick();
      chk($sformatf("vec%0d_in1", i), ex_in1, vt[i].e_in1);
      chk($sformatf("vec%0d_in2", i), ex_in2, vt[i].e_in2);
      chk($sformatf("vec%0d_store", i), ex_store_data, vt[i].e_st);
      chk($sformatf("vec%0d_valid", i), {31'd0, ex_valid}, {31'd0, vt[i].valid});
      chk($sformatf("vec%0d_ctrl", i), {28'd0, ex_alu_ctrl}, {28'd0, vt[i].ctrl});
    end

    // Capture-time WB bypass survives once MEM/WB moves on
    clr_fwd();
    set_id(5'd1, 5'd7, 32'd1, 32'd1, 32'd0, 1'b0, 4'b0001, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
    memwb_reg_write = 1'b1; memwb_dest = 5'd7; memwb_result = 32'h55;
    tick();
    memwb_reg_write = 1'b0;
    #1;
    chk("bypass_rt", ex_in2, 32'h55);
    chk("bypass_rs_none", ex_in1, 32'd1);

    // Forward priority
    clr_fwd();
    set_id(5'd3, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, 4'b0001, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    exmem_reg_write = 1'b1; exmem_dest = 5'd3; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_dest = 5'd3; memwb_result = 32'hBB;
    #1; chk("fwd_exmem_first", ex_in1, 32'hAA);
    exmem_reg_write = 1'b0;
    #1; chk("fwd_memwb", ex_in1, 32'hBB);
    exmem_reg_write = 1'b1; exmem_dest = 5'd0; memwb_dest = 5'd0;
    #1; chk("fwd_none", ex_in1, 32'd1);

    // Load-use bubble
    clr_fwd();
    set_id(5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd4, 5'd5, 32'h99, 32'h5, 32'd0, 1'b0, 4'b0001, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1);
    #1; chk("lu_stall", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bub_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("lu_bub_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("lu_bub_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
    chk("lu_bub_dest", {27'd0, ex_dest}, 32'd0);
    chk("lu_bub_stall", {31'd0, stall}, 32'd0);
    tick();
    exmem_reg_write = 1'b1; exmem_dest = 5'd4; exmem_result = 32'h1234;
    #1;
    chk("lu_cap_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cap_in1", ex_in1, 32'h1234);
    chk("lu_cap_dest", {27'd0, ex_dest}, 32'd6);

    // Immediate store hazard on rt
    clr_fwd();
    set_id(5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd2, 5'd6, 32'h20, 32'h77, 32'h10, 1'b1, 4'b0001, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1; chk("st_stall", {31'd0, stall}, 32'd1);
    id_mem_write = 1'b0;
    #1; chk("imm_no_stall", {31'd0, stall}, 32'd0);
    id_mem_write = 1'b1; id_valid = 1'b0;
    #1; chk("invalid_no_stall", {31'd0, stall}, 32'd0);
    id_valid = 1'b1;
    tick();
    tick();
    exmem_reg_write = 1'b1; exmem_dest = 5'd6; exmem_result = 32'hC0DE;
    #1;
    chk("st_in2_imm", ex_in2, 32'h10);
    chk("st_store_fwd", ex_store_data, 32'hC0DE);
    chk("st_mw", {31'd0, ex_mem_write}, 32'd1);

    // Flush overrides a hazard without stalling
    clr_fwd();
    set_id(5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd4, 5'd5, 32'h1, 32'h2, 32'd0, 1'b0, 4'b0001, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1; chk("flush_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_rw", {31'd0, ex_reg_write}, 32'd0);

    // Hold keeps contents while forwarding tracks EX/MEM
    set_id(5'd9, 5'd10, 32'h100, 32'h200, 32'd0, 1'b0, 4'b0001, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("hold_pre_in1", ex_in1, 32'h100);
    hold = 1'b1;
    set_id(5'd12, 5'd13, 32'h5, 32'h6, 32'd0, 1'b0, 4'b0101, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exmem_reg_write = 1'b1; exmem_dest = 5'd9; exmem_result = 32'h300 + 32'(i);
      tick();
      chk($sformatf("hold%0d_valid", i), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("hold%0d_dest", i), {27'd0, ex_dest}, 32'd11);
      chk($sformatf("hold%0d_ctrl", i), {28'd0, ex_alu_ctrl}, 32'd1);
      chk($sformatf("hold%0d_in1", i), ex_in1, 32'h300 + 32'(i));
    end
    hold = 1'b0;

    // Async reset while a stall is pending
    clr_fwd();
    set_id(5'd1, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 4'b0001, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    set_id(5'd4, 5'd2, 32'h44, 32'h2, 32'd0, 1'b0, 4'b0001, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
    #1; chk("rst_pre_stall", {31'd0, stall}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_mr", {31'd0, ex_mem_read}, 32'd0);
    chk("rst_rw", {31'd0, ex_reg_write}, 32'd0);
    chk("rst_ctrl", {28'd0, ex_alu_ctrl}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    #1 reset = 1'b1;
    tick();
    chk("rst_resume_valid", {31'd0, ex_valid}, 32'd1);
    chk("rst_resume_dest", {27'd0, ex_dest}, 32'd8);
    chk("rst_resume_in1", ex_in1, 32'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
